// File: rtl/cnter_rr_arb_pkg.sv
// rtl/cnter_rr_arb_pkg.sv - shared state encodings and default sizes for the counter arbiter
package cnter_rr_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_COUNT = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam int DEF_NREQ  = 2;
   localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/cnter_rr_arb_if.sv
// rtl/cnter_rr_arb_if.sv - requester-side bundle between requesters and the counter arbiter
interface cnter_rr_arb_if #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 4
);
   logic [NREQ-1:0]       req_i;
   logic [NREQ*WIDTH-1:0] len_i;
   logic [NREQ-1:0]       gnt_o;
   logic [NREQ-1:0]       done_o;
   logic                  busy_o;
   logic [WIDTH-1:0]      cnt_o;

   modport master (
      output req_i, len_i,
      input  gnt_o, done_o, busy_o, cnt_o
   );

   modport slave (
      input  req_i, len_i,
      output gnt_o, done_o, busy_o, cnt_o
   );
endinterface

// File: rtl/cnter_rr_arb_sync_cnter.sv
// rtl/cnter_rr_arb_sync_cnter.sv - shared up-counter, synchronous clear wins over enable
module sync_cnter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (en_i) begin
         cnt_o <= cnt_o + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cnter_rr_arb.sv
// rtl/cnter_rr_arb.sv - round-robin scheduler granting timed runs of one shared counter
import cnter_rr_arb_pkg::*;

module cnter_rr_arb #(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   cnter_rr_arb_if.slave  bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e            state_q, state_d;
   logic [IW-1:0]     win_q, last_q, pick_idx;
   logic [WIDTH-1:0]  len_q, pick_len, cnt;
   logic [NREQ-1:0]   win_oh;
   logic              pick_vld, win_req, clr, en;

   // Search upward from the slot after the last winner, wrapping modulo NREQ.
   always_comb begin
      int j;
      j        = 0;
      pick_vld = 1'b0;
      pick_idx = '0;
      pick_len = '0;
      for (int i = 1; i <= NREQ; i++) begin
         j = (int'(last_q) + i) % NREQ;
         if (!pick_vld && bus.req_i[j]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(j);
            pick_len = bus.len_i[j*WIDTH +: WIDTH];
         end
      end
   end

   assign win_req = bus.req_i[win_q];
   assign win_oh  = NREQ'(1) << win_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pick_vld) state_d = S_LOAD;
         S_LOAD:  state_d = win_req ? S_COUNT : S_IDLE;
         S_COUNT: begin
            if (!win_req) begin
               state_d = S_IDLE;
            end else if (cnt == len_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.gnt_o  = '0;
      bus.done_o = '0;
      bus.busy_o = 1'b0;
      clr        = 1'b0;
      en         = 1'b0;
      case (state_q)
         S_LOAD: begin
            bus.gnt_o  = win_oh;
            bus.busy_o = 1'b1;
            clr        = 1'b1;
         end
         S_COUNT: begin
            bus.gnt_o  = win_oh;
            bus.busy_o = 1'b1;
            en         = win_req && (cnt != len_q);
         end
         S_DONE: begin
            bus.gnt_o  = win_oh;
            bus.done_o = win_oh;
            bus.busy_o = 1'b1;
         end
         default: ;
      endcase
   end

   // An aborted run still moves the pointer, so the aborter drops to lowest priority.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         win_q  <= '0;
         len_q  <= '0;
         last_q <= IW'(NREQ - 1);
      end else begin
         if (state_q == S_IDLE && pick_vld) begin
            win_q <= pick_idx;
            len_q <= pick_len;
         end
         if (state_q == S_DONE ||
             ((state_q == S_LOAD || state_q == S_COUNT) && !win_req)) begin
            last_q <= win_q;
         end
      end
   end

   sync_cnter #(
      .WIDTH (WIDTH)
   ) u_cnter (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr),
      .en_i   (en),
      .cnt_o  (cnt)
   );

   assign bus.cnt_o = cnt;

endmodule

// File: tb/tb_cnter_rr_arb.sv
// tb/tb_cnter_rr_arb.sv - directed self-checking bench for cnter_rr_arb
module tb_cnter_rr_arb;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   cnter_rr_arb_if #(.NREQ(2), .WIDTH(4)) bus ();

   cnter_rr_arb #(
      .NREQ  (2),
      .WIDTH (4)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      bus.req_i  = 2'b00;
      bus.len_i  = 8'h00;
      step();
      rst_n = 1'b1;
   endtask

   task automatic check_idle(input string tag, input logic [3:0] cnt_exp);
      check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
      check({tag, "_gnt"},  32'(bus.gnt_o),  32'd0);
      check({tag, "_done"}, 32'(bus.done_o), 32'd0);
      check({tag, "_cnt"},  32'(bus.cnt_o),  32'(cnt_exp));
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      bus.req_i = 2'b00;
      bus.len_i = 8'h00;
      repeat (2) @(negedge clk);
      check_idle("rst", 4'd0);

      // Reset mid-run, then first-priority grant to requester 0
      do_reset();
      bus.len_i = 8'h05;
      bus.req_i = 2'b01;
      repeat (4) step();
      check("t1_midrun_cnt", 32'(bus.cnt_o), 32'd2);
      rst_n = 1'b0;
      #1;
      check_idle("t1_async", 4'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      bus.len_i = 8'h22;
      bus.req_i = 2'b11;
      step();
      check("t1_gnt_first", 32'(bus.gnt_o), 32'h1);

      // Single run len=5: cnt 0..5, done at t+8, idle at t+9
      do_reset();
      bus.len_i = 8'h35;
      bus.req_i = 2'b01;
      step();
      check("t2_gnt", 32'(bus.gnt_o), 32'h1);
      check("t2_busy", 32'(bus.busy_o), 32'd1);
      bus.len_i = 8'h32;
      for (int k = 0; k <= 5; k++) begin
         step();
         check($sformatf("t2_cnt%0d", k), 32'(bus.cnt_o), 32'(k));
         check($sformatf("t2_nodone%0d", k), 32'(bus.done_o), 32'd0);
      end
      step();
      check("t2_done", 32'(bus.done_o), 32'h1);
      check("t2_done_gnt", 32'(bus.gnt_o), 32'h1);
      check("t2_done_cnt", 32'(bus.cnt_o), 32'd5);
      bus.req_i = 2'b00;
      step();
      check_idle("t2_end", 4'd5);

      // len=0 on requester 1
      do_reset();
      bus.len_i = 8'h07;
      bus.req_i = 2'b10;
      step();
      check("t3_gnt", 32'(bus.gnt_o), 32'h2);
      step();
      check("t3_count_cnt", 32'(bus.cnt_o), 32'd0);
      check("t3_count_nodone", 32'(bus.done_o), 32'd0);
      step();
      check("t3_done", 32'(bus.done_o), 32'h2);
      check("t3_done_cnt", 32'(bus.cnt_o), 32'd0);
      bus.req_i = 2'b00;
      step();
      check_idle("t3_end", 4'd0);

      // Fairness: both held, len 2 each
      do_reset();
      bus.len_i = 8'h22;
      bus.req_i = 2'b11;
      for (int r = 0; r < 4; r++) begin
         logic [1:0] exp_g;
         exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
         step();
         check($sformatf("t4_gnt%0d", r), 32'(bus.gnt_o), 32'(exp_g));
         repeat (3) step();
         check($sformatf("t4_cnt%0d", r), 32'(bus.cnt_o), 32'd2);
         step();
         check($sformatf("t4_done%0d", r), 32'(bus.done_o), 32'(exp_g));
         step();
         check($sformatf("t4_idle%0d", r), 32'(bus.busy_o), 32'd0);
      end

      // Abort requester 0 at cnt=3 of len=9; requester 1 follows
      do_reset();
      bus.len_i = 8'h39;
      bus.req_i = 2'b11;
      step();
      check("t5_gnt0", 32'(bus.gnt_o), 32'h1);
      repeat (4) step();
      check("t5_cnt3", 32'(bus.cnt_o), 32'd3);
      bus.req_i = 2'b10;
      step();
      check_idle("t5_abort", 4'd3);
      step();
      check("t5_gnt1", 32'(bus.gnt_o), 32'h2);
      check("t5_busy1", 32'(bus.busy_o), 32'd1);

      // Max len=15: no wrap; len change after sampling is ignored
      do_reset();
      bus.len_i = 8'h0F;
      bus.req_i = 2'b01;
      step();
      check("t6_gnt", 32'(bus.gnt_o), 32'h1);
      bus.len_i = 8'h02;
      for (int k = 0; k <= 15; k++) begin
         step();
         check($sformatf("t6_cnt%0d", k), 32'(bus.cnt_o), 32'(k));
      end
      step();
      check("t6_done", 32'(bus.done_o), 32'h1);
      check("t6_done_cnt", 32'(bus.cnt_o), 32'd15);
      bus.req_i = 2'b00;
      step();
      check_idle("t6_end", 4'd15);
      step();
      check("t6_hold_cnt", 32'(bus.cnt_o), 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
